// File: rtl/bbox_msg_pkg.sv
// Shared definitions for the bounding-box message reader.
// Holds the image-processor register map, the message ID word, the flush
// control bit, the coordinate field positions and the FSM state types.
package bbox_msg_pkg;

    // Register map of the image processor's Avalon slave
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_READ_MSG = 3'd1;
    localparam logic [2:0] ADDR_READ_ID  = 3'd2;
    localparam logic [2:0] ADDR_BBCOL    = 3'd3;

    localparam logic [31:0] RBB_MSG_ID = 32'h0052_4242;

    // Writing this bit of STATUS empties the slave's message FIFO
    localparam int unsigned FLUSH_BIT  = 4;
    localparam logic [31:0] FLUSH_WORD = 32'h1 << FLUSH_BIT;

    // STATUS[15:8] is the number of words buffered in the message FIFO
    localparam int unsigned USEDW_LSB = 8;
    localparam int unsigned USEDW_W   = 8;
    localparam int unsigned MSG_WORDS = 3;

    // Coordinate word layout: x in [26:16], y in [10:0]; other bits ignored
    localparam int unsigned COORD_W = 11;
    localparam int unsigned X_LSB   = 16;
    localparam int unsigned Y_LSB   = 0;

    typedef enum logic [3:0] {
        StCheckId,
        StPoll,
        StGap,
        StFlush,
        StRdId,
        StRdTl,
        StRdBr,
        StPresent,
        StHalt
    } state_e;

    // Phases of a single bus access
    typedef enum logic [1:0] {
        AccIdle,
        AccStrobe,
        AccWait
    } acc_e;

endpackage

// File: rtl/bbox_mm_access.sv
// Single-access Avalon-MM sequencer.
// A start pulse (accepted only while idle) launches one read or write whose
// chipselect and read/write strobe are high for exactly one cycle. Reads
// capture m_readdata READ_LATENCY cycles after the strobe cycle. done pulses
// for one cycle once the access completes; the strobe is never re-asserted
// before done, so every access is followed by at least one idle bus cycle.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, addr, wr, wdata  access request (sampled when start is high)
//   done, rdata             completion pulse and captured read data
//   m_*                     Avalon-MM master signals
module bbox_mm_access
    import bbox_msg_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata
);

    acc_e        acc_q, acc_d;
    logic [2:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  lat_q, lat_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;

    always_comb begin
        acc_d   = acc_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        lat_d   = lat_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (acc_q)
            AccIdle: begin
                if (start) begin
                    addr_d  = addr;
                    wr_d    = wr;
                    wdata_d = wr ? wdata : '0;
                    acc_d   = AccStrobe;
                end
            end
            AccStrobe: begin
                if (wr_q) begin
                    done_d = 1'b1;
                    acc_d  = AccIdle;
                end else begin
                    lat_d = 8'(READ_LATENCY - 1);
                    acc_d = AccWait;
                end
            end
            AccWait: begin
                if (lat_q == 8'd0) begin
                    rdata_d = m_readdata;
                    done_d  = 1'b1;
                    acc_d   = AccIdle;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            default: acc_d = AccIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= AccIdle;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            lat_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Strobes decode straight from the flop so reset drops them at once
    assign m_chipselect = (acc_q == AccStrobe);
    assign m_read       = m_chipselect & ~wr_q;
    assign m_write      = m_chipselect & wr_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign done         = done_q;
    assign rdata        = rdata_q;

endmodule

// File: rtl/bbox_msg_reader.sv
// Bounding-box message reader.
// Avalon-MM master that checks the image processor's ID, polls its message
// FIFO status, drains complete 3-word RBB messages, realigns one word at a
// time on a bad ID word and presents each decoded box on a valid/ready
// stream (single-entry buffer). A flush request is held until the next poll
// so a message is never split.
// Optional feature macro: BBOX_CENTRE_EN adds box_cx/box_cy outputs.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   m_*                          Avalon-MM master to the 3-bit register slave
//   flush_req                    pulse requesting a message-FIFO flush
//   box_valid, box_ready         output stream handshake
//   box_x/y_min/max, box_empty   decoded box and empty flag
//   resync_count                 saturating count of discarded words
//   id_error                     sticky slave ID mismatch (reader halted)
//   box_cx, box_cy               box centre (BBOX_CENTRE_EN only)
module bbox_msg_reader
    import bbox_msg_pkg::*;
#(
    parameter int unsigned POLL_GAP        = 16,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned IMAGE_W         = 640,
    parameter logic [31:0] EXPECT_SLAVE_ID = 32'h1234EEE2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        flush_req,
    output logic        box_valid,
    input  logic        box_ready,
    output logic [10:0] box_x_min,
    output logic [10:0] box_y_min,
    output logic [10:0] box_x_max,
    output logic [10:0] box_y_max,
    output logic        box_empty,
    output logic [7:0]  resync_count,
    output logic        id_error
`ifdef BBOX_CENTRE_EN
    ,
    output logic [10:0] box_cx,
    output logic [10:0] box_cy
`endif
);

    // Empty frames are reported as x_min = IMAGE_W-1 > x_max = 0, which the
    // generic x_min > x_max test already covers; IMAGE_W only documents it.
    localparam logic [COORD_W-1:0] EMPTY_X_MIN = COORD_W'(IMAGE_W - 1);

    state_e        state_q, state_d;
    logic          issued_q, issued_d;
    logic [15:0]   gap_q, gap_d;
    logic          flush_pending_q, flush_pending_d;
    logic [7:0]    resync_q, resync_d;
    logic          id_error_q, id_error_d;
    logic          valid_q, valid_d;
    logic [10:0]   tl_x_q, tl_x_d, tl_y_q, tl_y_d;
    logic [10:0]   x_min_q, y_min_q, x_max_q, y_max_q;
    logic          empty_q;
    logic          box_load;

    logic          acc_start, acc_wr, acc_done;
    logic [2:0]    acc_addr;
    logic [31:0]   acc_wdata, acc_rdata;
    logic [USEDW_W-1:0] usedw;
    logic [10:0]   br_x, br_y;

    assign usedw = acc_rdata[USEDW_LSB +: USEDW_W];
    assign br_x  = acc_rdata[X_LSB +: COORD_W];
    assign br_y  = acc_rdata[Y_LSB +: COORD_W];

    bbox_mm_access #(
        .READ_LATENCY (READ_LATENCY)
    ) u_access (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (acc_start),
        .addr         (acc_addr),
        .wr           (acc_wr),
        .wdata        (acc_wdata),
        .done         (acc_done),
        .rdata        (acc_rdata),
        .m_chipselect (m_chipselect),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata)
    );

    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q;
        gap_d           = gap_q;
        flush_pending_d = flush_pending_q | flush_req;
        resync_d        = resync_q;
        id_error_d      = id_error_q;
        valid_d         = valid_q;
        tl_x_d          = tl_x_q;
        tl_y_d          = tl_y_q;
        box_load        = 1'b0;
        acc_start       = 1'b0;
        acc_addr        = ADDR_STATUS;
        acc_wr          = 1'b0;
        acc_wdata       = '0;

        case (state_q)
            StCheckId: begin
                acc_addr = ADDR_READ_ID;
                if (!issued_q) begin
                    acc_start = 1'b1;
                end else if (acc_done) begin
                    if (acc_rdata == EXPECT_SLAVE_ID) begin
                        state_d = StPoll;
                    end else begin
                        id_error_d = 1'b1;
                        state_d    = StHalt;
                    end
                end
            end
            StPoll: begin
                acc_addr = ADDR_STATUS;
                if (!issued_q) begin
                    if (flush_pending_q) state_d = StFlush;
                    else                 acc_start = 1'b1;
                end else if (acc_done) begin
                    if (usedw >= USEDW_W'(MSG_WORDS)) begin
                        state_d = StRdId;
                    end else begin
                        gap_d   = 16'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q == 16'd0) state_d = StPoll;
                else                gap_d   = gap_q - 16'd1;
            end
            StFlush: begin
                acc_addr  = ADDR_STATUS;
                acc_wr    = 1'b1;
                acc_wdata = FLUSH_WORD;
                if (!issued_q) begin
                    acc_start = 1'b1;
                    // Clear on issue so a request arriving from now on is kept
                    flush_pending_d = flush_req;
                end else if (acc_done) begin
                    state_d = StPoll;
                end
            end
            StRdId: begin
                acc_addr = ADDR_READ_MSG;
                if (!issued_q) begin
                    acc_start = 1'b1;
                end else if (acc_done) begin
                    if (acc_rdata == RBB_MSG_ID) begin
                        state_d = StRdTl;
                    end else begin
                        if (resync_q != 8'hFF) resync_d = resync_q + 8'd1;
                        state_d = StPoll;
                    end
                end
            end
            StRdTl: begin
                acc_addr = ADDR_READ_MSG;
                if (!issued_q) begin
                    acc_start = 1'b1;
                end else if (acc_done) begin
                    tl_x_d  = br_x;
                    tl_y_d  = br_y;
                    state_d = StRdBr;
                end
            end
            StRdBr: begin
                acc_addr = ADDR_READ_MSG;
                if (!issued_q) begin
                    acc_start = 1'b1;
                end else if (acc_done) begin
                    box_load = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = StPresent;
                end
            end
            StPresent: begin
                if (valid_q && box_ready) begin
                    valid_d = 1'b0;
                    state_d = StPoll;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StCheckId;
        endcase

        if (acc_start)     issued_d = 1'b1;
        else if (acc_done) issued_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StCheckId;
            issued_q        <= 1'b0;
            gap_q           <= '0;
            flush_pending_q <= 1'b0;
            resync_q        <= '0;
            id_error_q      <= 1'b0;
            valid_q         <= 1'b0;
            tl_x_q          <= '0;
            tl_y_q          <= '0;
        end else begin
            state_q         <= state_d;
            issued_q        <= issued_d;
            gap_q           <= gap_d;
            flush_pending_q <= flush_pending_d;
            resync_q        <= resync_d;
            id_error_q      <= id_error_d;
            valid_q         <= valid_d;
            tl_x_q          <= tl_x_d;
            tl_y_q          <= tl_y_d;
        end
    end

    // Box outputs only change on load, so they hold while box_valid is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_min_q <= '0;
            y_min_q <= '0;
            x_max_q <= '0;
            y_max_q <= '0;
            empty_q <= 1'b0;
        end else if (box_load) begin
            x_min_q <= tl_x_q;
            y_min_q <= tl_y_q;
            x_max_q <= br_x;
            y_max_q <= br_y;
            empty_q <= (tl_x_q > br_x);
        end
    end

`ifdef BBOX_CENTRE_EN
    logic [11:0] sum_x, sum_y;
    logic [10:0] cx_q, cy_q;

    assign sum_x = {1'b0, tl_x_q} + {1'b0, br_x};
    assign sum_y = {1'b0, tl_y_q} + {1'b0, br_y};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (box_load) begin
            cx_q <= (tl_x_q > br_x) ? 11'd0 : sum_x[11:1];
            cy_q <= (tl_x_q > br_x) ? 11'd0 : sum_y[11:1];
        end
    end

    assign box_cx = cx_q;
    assign box_cy = cy_q;
`endif

    assign box_valid    = valid_q;
    assign box_x_min    = x_min_q;
    assign box_y_min    = y_min_q;
    assign box_x_max    = x_max_q;
    assign box_y_max    = y_max_q;
    assign box_empty    = empty_q;
    assign resync_count = resync_q;
    assign id_error     = id_error_q;

    logic unused_empty_sentinel;
    assign unused_empty_sentinel = ^EMPTY_X_MIN;

endmodule

// File: tb/tb_bbox_msg_reader.sv
// Testbench for bbox_msg_reader: behavioural register slave with a message
// FIFO, a protocol monitor and a queue of expected boxes.
module tb_bbox_msg_reader;

    localparam int unsigned POLL_GAP      = 16;
    // Poll issue, strobe, data return, completion
    localparam int unsigned ACCESS_CYCLES = 4;
    localparam logic [31:0] GOOD_ID       = 32'h1234EEE2;
    localparam logic [31:0] RBB           = 32'h00524242;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m_chipselect, m_read, m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        flush_req = 1'b0;
    logic        box_valid;
    logic        box_ready = 1'b0;
    logic [10:0] box_x_min, box_y_min, box_x_max, box_y_max;
    logic        box_empty;
    logic [7:0]  resync_count;
    logic        id_error;
`ifdef BBOX_CENTRE_EN
    logic [10:0] box_cx, box_cy;
`endif

    bbox_msg_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m_chipselect (m_chipselect),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .flush_req    (flush_req),
        .box_valid    (box_valid),
        .box_ready    (box_ready),
        .box_x_min    (box_x_min),
        .box_y_min    (box_y_min),
        .box_x_max    (box_x_max),
        .box_y_max    (box_y_max),
        .box_empty    (box_empty),
        .resync_count (resync_count),
        .id_error     (id_error)
`ifdef BBOX_CENTRE_EN
        ,
        .box_cx       (box_cx),
        .box_cy       (box_cy)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [44:0] exp_q[$];
    logic [44:0] exp_box;
    logic [44:0] got_box;
    assign got_box = {box_empty, box_x_min, box_y_min, box_x_max, box_y_max};

    // Slave model state
    logic [31:0] fifo[$];
    logic [31:0] slave_id = GOOD_ID;
    int          rd_cnt[8];
    int          wr_cnt, viol, cyc, first_addr, hs_cyc, wr_cyc;
    int          last_poll_cyc, prev_poll_cyc;
    logic [31:0] last_wdata;
    logic [2:0]  last_waddr;
    logic        prev_strobe = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_chipselect && (m_read || m_write)) begin
            if (prev_strobe) viol = viol + 1;
            if (m_read && m_write) viol = viol + 1;
            if (first_addr < 0) first_addr = int'(m_address);
        end
        if ((m_read || m_write) && !m_chipselect) viol = viol + 1;
        prev_strobe = m_chipselect && (m_read || m_write);
        if (box_valid && box_ready) hs_cyc = cyc;
        if (m_chipselect && m_read) begin
            rd_cnt[m_address] = rd_cnt[m_address] + 1;
            case (m_address)
                3'd0: begin
                    m_readdata <= {16'h0, 8'(fifo.size()), 8'h0};
                    prev_poll_cyc = last_poll_cyc;
                    last_poll_cyc = cyc;
                end
                3'd1: m_readdata <= (fifo.size() > 0) ? fifo.pop_front() : 32'h0;
                3'd2: m_readdata <= slave_id;
                default: m_readdata <= 32'h0;
            endcase
        end
        if (m_chipselect && m_write) begin
            wr_cnt     = wr_cnt + 1;
            wr_cyc     = cyc;
            last_wdata = m_writedata;
            last_waddr = m_address;
            if (m_address == 3'd0 && m_writedata[4]) fifo.delete();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Holds the DUT in reset with a fresh slave; caller loads FIFO then releases
    task automatic hold_reset(input logic [31:0] id);
        @(negedge clk);
        reset_n   = 1'b0;
        box_ready = 1'b0;
        flush_req = 1'b0;
        fifo.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) rd_cnt[i] = 0;
        wr_cnt = 0; first_addr = -1; hs_cyc = 0; wr_cyc = 0;
        last_poll_cyc = 0; prev_poll_cyc = 0;
        last_wdata = '0; last_waddr = '0;
        slave_id = id;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_msg(input int x0, input int y0, input int x1, input int y1,
                            input logic [4:0] junk);
        fifo.push_back(RBB);
        fifo.push_back({junk, 11'(x0), junk, 11'(y0)});
        fifo.push_back({junk, 11'(x1), junk, 11'(y1)});
        exp_q.push_back({(x0 > x1), 11'(x0), 11'(y0), 11'(x1), 11'(y1)});
    endtask

    task automatic wait_box(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (box_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        hold_reset(GOOD_ID);
        n_cmp++;
        if ({m_chipselect, m_read, m_write, box_valid, box_empty, id_error} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {m_chipselect, m_read, m_write, box_valid, box_empty, id_error});
        end
        n_cmp++;
        if ({got_box, resync_count, m_address, m_writedata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: box=%h resync=%0d addr=%0d wdata=%h required all 0",
                     got_box, resync_count, m_address, m_writedata);
        end
    endtask

    task automatic test_startup_ok();
        bit seen = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_cnt[0] > 0) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL startup_poll: got no STATUS read required one within 40 cycles");
        end
        n_cmp++;
        if (first_addr !== 2) begin
            n_fail++;
            $display("FAIL startup_first_addr: got %0d required 2", first_addr);
        end
        n_cmp++;
        if (id_error !== 1'b0) begin
            n_fail++;
            $display("FAIL startup_id_error: got %b required 0", id_error);
        end
    endtask

    task automatic test_startup_bad();
        int strobes;
        hold_reset(32'hDEADBEEF);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (id_error !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_id_error: got %b required 1", id_error);
        end
        strobes = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] + wr_cnt;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] + wr_cnt !== 1 || strobes !== 1) begin
            n_fail++;
            $display("FAIL bad_id_halt: got %0d then %0d accesses required 1 and 1", strobes,
                     rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] + wr_cnt);
        end
    endtask

    task automatic test_normal();
        bit seen;
        hold_reset(GOOD_ID);
        push_msg(100, 50, 200, 120, 5'h0);
        box_ready = 1'b1;
        reset_n = 1'b1;
        wait_box(200, seen);
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL normal_valid: got no box_valid required one within 200 cycles");
        end else begin
            exp_box = exp_q.pop_front();
            n_cmp++;
            if (got_box !== exp_box) begin
                n_fail++;
                $display("FAIL normal_box: got %h required %h", got_box, exp_box);
            end
            n_cmp++;
            if (rd_cnt[0] !== 1 || rd_cnt[1] !== 3) begin
                n_fail++;
                $display("FAIL normal_reads: got status=%0d msg=%0d required 1 and 3",
                         rd_cnt[0], rd_cnt[1]);
            end
`ifdef BBOX_CENTRE_EN
            n_cmp++;
            if ({box_cx, box_cy} !== {11'd150, 11'd85}) begin
                n_fail++;
                $display("FAIL normal_centre: got %0d,%0d required 150,85", box_cx, box_cy);
            end
`endif
            @(negedge clk);
            n_cmp++;
            if (box_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL normal_valid_drop: got %b required 0", box_valid);
            end
        end
    endtask

    task automatic test_empty();
        bit seen;
        hold_reset(GOOD_ID);
        push_msg(639, 479, 0, 0, 5'h1F);
        box_ready = 1'b1;
        reset_n = 1'b1;
        wait_box(200, seen);
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL empty_valid: got no box_valid required one within 200 cycles");
        end else begin
            exp_box = exp_q.pop_front();
            n_cmp++;
            if (got_box !== exp_box) begin
                n_fail++;
                $display("FAIL empty_box: got %h required %h", got_box, exp_box);
            end
        end
    endtask

    task automatic test_resync();
        bit seen;
        hold_reset(GOOD_ID);
        fifo.push_back(32'h0000_0123);
        push_msg(10, 20, 30, 40, 5'h0);
        box_ready = 1'b1;
        reset_n = 1'b1;
        wait_box(300, seen);
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL resync_valid: got no box_valid required one within 300 cycles");
        end else begin
            exp_box = exp_q.pop_front();
            n_cmp++;
            if (got_box !== exp_box) begin
                n_fail++;
                $display("FAIL resync_box: got %h required %h", got_box, exp_box);
            end
            n_cmp++;
            if (resync_count !== 8'd1) begin
                n_fail++;
                $display("FAIL resync_count: got %0d required 1", resync_count);
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        int rd1, unstable, base;
        logic [44:0] snap;
        hold_reset(GOOD_ID);
        push_msg(1, 2, 3, 4, 5'h0);
        push_msg(5, 6, 7, 8, 5'h0);
        reset_n = 1'b1;
        wait_box(200, seen);
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_valid: got no box_valid required one within 200 cycles");
            return;
        end
        exp_box = exp_q.pop_front();
        n_cmp++;
        if (got_box !== exp_box) begin
            n_fail++;
            $display("FAIL bp_box1: got %h required %h", got_box, exp_box);
        end
        snap = got_box;
        rd1 = rd_cnt[1];
        unstable = 0;
        repeat (50) begin
            @(negedge clk);
            if (!box_valid || got_box !== snap) unstable++;
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable cycles required 0", unstable);
        end
        n_cmp++;
        if (rd_cnt[1] !== rd1) begin
            n_fail++;
            $display("FAIL bp_no_read: got %0d msg reads required %0d", rd_cnt[1], rd1);
        end
        box_ready = 1'b1;
        @(negedge clk);
        wait_box(200, seen);
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_valid2: got no second box required one within 200 cycles");
            return;
        end
        exp_box = exp_q.pop_front();
        n_cmp++;
        if (got_box !== exp_box) begin
            n_fail++;
            $display("FAIL bp_box2: got %h required %h", got_box, exp_box);
        end
        // Two buffered words is not a full message: reader must keep polling
        fifo.push_back(32'hCAFE_0001);
        fifo.push_back(32'hCAFE_0002);
        base = rd_cnt[0];
        for (int i = 0; i < 200 && rd_cnt[0] < base + 3; i++) @(negedge clk);
        n_cmp++;
        if (last_poll_cyc - prev_poll_cyc !== int'(POLL_GAP + ACCESS_CYCLES)) begin
            n_fail++;
            $display("FAIL poll_gap: got %0d cycles required %0d",
                     last_poll_cyc - prev_poll_cyc, POLL_GAP + ACCESS_CYCLES);
        end
        n_cmp++;
        if (rd_cnt[1] !== 6 || fifo.size() !== 2) begin
            n_fail++;
            $display("FAIL poll_partial: got msg reads=%0d fifo=%0d required 6 and 2",
                     rd_cnt[1], fifo.size());
        end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        hold_reset(GOOD_ID);
        push_msg(11, 22, 33, 44, 5'h0);
        fifo.push_back(32'hAAAA_0001);
        fifo.push_back(32'hAAAA_0002);
        box_ready = 1'b1;
        reset_n = 1'b1;
        // Pulse flush_req while the top-left word is being read
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_read && m_address == 3'd1 && rd_cnt[1] == 1) begin
                flush_req = 1'b1;
                @(negedge clk);
                flush_req = 1'b0;
                break;
            end
        end
        wait_box(200, seen);
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL flush_valid: got no box_valid required one within 200 cycles");
            return;
        end
        exp_box = exp_q.pop_front();
        n_cmp++;
        if (got_box !== exp_box) begin
            n_fail++;
            $display("FAIL flush_box: got %h required %h", got_box, exp_box);
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (wr_cnt !== 1 || last_waddr !== 3'd0 || last_wdata !== 32'h10) begin
            n_fail++;
            $display("FAIL flush_write: got n=%0d addr=%0d data=%h required 1, 0, 00000010",
                     wr_cnt, last_waddr, last_wdata);
        end
        n_cmp++;
        if (!(wr_cyc > hs_cyc) || rd_cnt[1] !== 3 || fifo.size() !== 0) begin
            n_fail++;
            $display("FAIL flush_order: got wr@%0d hs@%0d reads=%0d fifo=%0d required wr>hs,3,0",
                     wr_cyc, hs_cyc, rd_cnt[1], fifo.size());
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        hold_reset(GOOD_ID);
        push_msg(5, 5, 9, 9, 5'h0);
        box_ready = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_read && m_address == 3'd1 && rd_cnt[1] == 2) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rstmid_reach: got no bottom-right read required one");
            return;
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_read, m_chipselect, box_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_strobe: got %b required 000", {m_read, m_chipselect, box_valid});
        end
        first_addr = -1;
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20 && first_addr < 0; i++) @(negedge clk);
        n_cmp++;
        if (first_addr !== 2) begin
            n_fail++;
            $display("FAIL rstmid_restart: got first addr %0d required 2", first_addr);
        end
    endtask

    initial begin
        viol = 0;
        cyc = 0;
        test_reset();
        test_startup_ok();
        test_startup_bad();
        test_normal();
        test_empty();
        test_resync();
        test_backpressure();
        test_flush();
        test_reset_mid();
        n_cmp++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL protocol: got %0d strobe violations required 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bbox_msg_reader.md
Name: bbox_msg_reader

Overview:
Hardware consumer of the vision block's bounding-box message FIFO. It is an Avalon-MM master on the image processor's 3-bit register slave. It polls the status register, drains complete 3-word "RBB" messages, validates the ID word and presents decoded box coordinates on a valid/ready stream to drive-control logic. This removes the need for the Nios to service the message FIFO.

Parameters:
POLL_GAP, 16, idle cycles between status polls when fewer than 3 words are buffered
READ_LATENCY, 1, cycles from read strobe to valid m_readdata (slave registers readdata)
IMAGE_W, 640, frame width; used for empty-box detection
EXPECT_SLAVE_ID, 32'h1234EEE2, value required at slave address 2 during startup

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m_chipselect  out  1  slave select
m_read  out  1  read strobe, one cycle per access
m_write  out  1  write strobe, one cycle per access
m_address  out  3  0=STATUS 1=READ_MSG 2=READ_ID 3=BBCOL
m_writedata  out  32  write data (flush only)
m_readdata  in  32  slave read data
flush_req  in  1  pulse: request message-FIFO flush
box_valid  out  1  decoded box available
box_ready  in  1  consumer accepts box
box_x_min, box_y_min, box_x_max, box_y_max  out  11 each  box corners
box_empty  out  1  no detection in frame (x_min > x_max)
resync_count  out  8  saturating count of discarded non-ID words
id_error  out  1  sticky: slave ID mismatch at startup; reader halted

Behaviour:
- Reset: all outputs 0; FSM in CHECK_ID; flush_pending cleared. Asserting reset mid-access abandons it. The slave never sees more than the one strobe already issued.
- Access rule: each access is m_chipselect plus m_read or m_write high for exactly 1 cycle. At least 1 idle cycle follows, because the slave pops the FIFO only on a read rising edge.
- Read data is captured exactly READ_LATENCY cycles after the strobe cycle.
- States:
  - CHECK_ID: read addr 2. If data == EXPECT_SLAVE_ID, go to POLL. Otherwise set id_error and go to HALT, which is terminal until reset.
  - POLL: if flush_pending, go to FLUSH. Otherwise read addr 0 and set usedw = data[15:8].
    - usedw >= 3: go to RD_ID.
    - Otherwise: go to GAP.
  - GAP: wait POLL_GAP cycles, then go to POLL.
  - FLUSH: write addr 0 with data 32'h10, clear flush_pending, go to POLL.
  - RD_ID: read addr 1.
    - Data == 32'h00524242 ("RBB"): go to RD_TL.
    - Otherwise: resync_count++ (saturates at 255), go to POLL. Only one word is consumed, so the reader realigns one word at a time.
  - RD_TL: read addr 1; latch x_min = data[26:16], y_min = data[10:0].
  - RD_BR: read addr 1; latch x_max and y_max the same way; go to PRESENT.
  - PRESENT: drive box_* outputs and set box_valid = 1. Hold outputs stable until box_valid & box_ready, then box_valid = 0 next cycle and go to POLL.
- box_empty = (x_min > x_max), registered together with the coordinates. The empty sentinel is x_min = IMAGE_W-1, x_max = 0.
- flush_req is latched into flush_pending in any state. It is serviced only at POLL entry, so an in-progress 3-word message is never split. A flush_req arriving on the same cycle as the FLUSH write is retained for the next POLL.
- No new message is read while box_valid is high (single-entry output buffer). Backpressure therefore leaves messages queued in the slave FIFO.
- Bits [31:27] and [15:11] of coordinate words are ignored.

Optional Feature:
BBOX_CENTRE_EN
- Defined: adds outputs box_cx and box_cy (11 bits each) = (min + max) >> 1. They are computed with a 12-bit intermediate and registered in the same cycle as the box_* outputs. Both are 0 when box_empty.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package bbox_msg_pkg holds:
  - register address constants (STATUS, READ_MSG, READ_ID, BBCOL);
  - RBB_MSG_ID = 32'h00524242;
  - FLUSH_BIT = 4;
  - the FSM state enum;
  - the coordinate field slice positions.
- Sub-module bbox_mm_access: a single-access Avalon sequencer. It takes a start pulse, address, write flag and data. It returns done plus captured rdata after READ_LATENCY, and enforces the idle gap. The top FSM sequences accesses through it.

Test Plan:
- Startup ID: slave returns 32'h1234EEE2 at addr 2 -> enters POLL, issues a read of addr 0, id_error = 0. Returning 32'hDEADBEEF instead -> id_error = 1 and no further strobes for 100 cycles.
- Normal message: usedw = 3, FIFO {00524242, {5'b0,11'd100,5'b0,11'd50}, {5'b0,11'd200,5'b0,11'd120}}, box_ready = 1 -> box_valid pulses with (100,50,200,120), box_empty = 0. Exactly 4 reads are issued, each 1 cycle wide with gaps.
- Empty box: corner words (639,479) and (0,0) -> box_empty = 1, coordinates passed unchanged.
- Resync: FIFO {00000123, 00524242, TL, BR} -> resync_count = 1 and the correct box follows.
- Backpressure and poll gap: box_ready held 0 for 50 cycles -> outputs stable, no addr-1 reads during that time. usedw = 2 -> addr-0 reads spaced POLL_GAP + access cycles apart.
- Flush: flush_req mid-RD_TL -> message completes first, then one write of 32'h10 to addr 0. Separately, reset asserted mid-RD_BR -> m_read = 0 immediately and the FSM restarts at CHECK_ID.
